serial_fifo_ctrl: RTL and testbench
===================================

Name: serial_fifo_ctrl

Overview:
- Successor to the single-byte serial controller. Sits between the device controller's COM select and the async UART receiver/transmitter pair.
- Adds parametrised RX/TX FIFOs, a four-register map, a programmable RX interrupt threshold and sticky overrun flags.
- Keeps data at offset 0x0 and status at 0x4 with the existing bit meanings, so monitor and kernel polling code run unchanged.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO; power of two, at least 2.
- CHAR_WIDTH, 8, bits per character on the UART side.
- RX_THRESH_RST, 1, reset value of the RX interrupt threshold field.

Ports:
- clk  input  1  system clock (clk25).
- rst  input  1  asynchronous active-low reset.
- enable_i  input  1  device selected this cycle.
- readEnable_i  input  1  1 = read, 0 = write (when enable_i = 1).
- addr_i  input  2  word offset, taken from physical address [3:2].
- dataSave_i  input  32  write data.
- dataLoad_o  output  32  read data, combinational.
- int_o  output  1  registered, level interrupt request.
- rxdReady_i  input  1  one-cycle pulse: new character from the receiver.
- rxdData_i  input  CHAR_WIDTH  received character.
- txdBusy_i  input  1  transmitter busy.
- txdStart_o  output  1  one-cycle start pulse to the transmitter.
- txdData_o  output  CHAR_WIDTH  character to send, registered.

Behaviour:
Reset (asynchronous):
- Both FIFOs are emptied.
- txdStart_o = 0, txdData_o = 0, int_o = 0.
- Control register = 0, with threshold = RX_THRESH_RST.
- Sticky flags are cleared and the TX FSM goes to IDLE.

Register map:
- 0x0 DATA
  - Read returns the RX head, zero-extended, and pops it on the clock edge. If RX is empty, the read returns 0 and does not pop.
  - Write pushes dataSave_i[CHAR_WIDTH-1:0] into TX.
- 0x4 STATUS (read-only)
  - bit0 = TX not full; bit1 = RX not empty; bit2 = RX overrun (sticky); bit3 = TX overflow (sticky).
  - A read clears bits 2 and 3 on the clock edge.
- 0x8 CTRL (read/write)
  - bit0 = RX interrupt enable; bit1 = TX-empty interrupt enable.
  - bits[15:8] = RX threshold; the value 0 is treated as 1.
- 0xC LEVEL (read-only)
  - [15:0] = RX count; [31:16] = TX count.
  - Counts range 0..FIFO_DEPTH inclusive.

RX path:
- On rxdReady_i, push rxdData_i.
- If RX is full and no pop happens in the same cycle, drop the character and set overrun.
- A simultaneous push and pop on a full FIFO accepts both; the level is unchanged.

TX path:
- A write to DATA when TX is full is dropped and sets TX overflow.
- A push and an FSM pop in the same cycle on a full FIFO both succeed.

TX FSM, states IDLE, START, GUARD:
- IDLE -> START when TX is not empty and txdBusy_i = 0.
- START: pop the head into txdData_o and drive txdStart_o = 1 for exactly one cycle, then go to GUARD.
- GUARD: wait one cycle (covers busy-assert latency), then go to IDLE.
- Minimum spacing between start pulses is 3 cycles, plus whatever txdBusy_i adds.

Interrupt:
- int_o next state = (CTRL.bit0 & RX count >= threshold) | (CTRL.bit1 & TX empty & FSM in IDLE & !txdBusy_i).
- int_o lags the condition by 1 cycle.

FIFO structure:
- Pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are detected from the MSB compare; wrap-around is by natural overflow.

Other rules:
- Reads and writes to undefined bits return 0 / are ignored.
- Writes to STATUS and LEVEL are ignored.
- Reset during a transmission: txdStart_o drops immediately. A character already handed to the transmitter completes outside this block.

Optional Feature:
- Macro: SERIAL_FIFO_LOOPBACK_EN.
- When defined:
  - CTRL bit2 = loopback.
  - When bit2 = 1, the START pop feeds the RX push in the same cycle, and txdStart_o stays 0.
  - RX overrun rules still apply.
  - rxdReady_i is ignored while loopback = 1.
- When undefined: CTRL bit2 reads 0 and writes to it are ignored. No loopback logic is built.

Decomposition:
- Shared header serial_fifo_defs.vh contains:
  - Register offsets (DATA 2'd0, STATUS 2'd1, CTRL 2'd2, LEVEL 2'd3).
  - STATUS and CTRL bit positions.
  - TX FSM state encodings.
- One sub-module, sync_fifo (parameters DEPTH and WIDTH; push/pop/full/empty/count/head), instantiated twice.

Test Plan:
- Write 0x41, 0x42, 0x43 to DATA with txdBusy_i held 0 -> three txdStart_o pulses at least 3 cycles apart, with txdData_o = 0x41, 0x42, 0x43 in order; LEVEL[31:16] returns to 0.
- Write 17 characters with txdBusy_i = 1 and FIFO_DEPTH = 16 -> STATUS bit0 = 0 after the 16th write; STATUS = 0x8 after the 17th; the next STATUS read shows bit3 cleared.
- Pulse rxdReady_i 17 times with 0x00..0x10 -> RX count = 16, STATUS bit2 = 1; DATA reads return 0x00..0x0F, then 0 once empty.
- CTRL = 0x0301, push 2 RX characters -> int_o stays 0; push a 3rd -> int_o = 1 one cycle later; pop 1 -> int_o = 0 one cycle later.
- RX full with a DATA read and an rxdReady_i pulse in the same cycle -> no overrun, count stays 16, and the new character appears last.
- Assert rst mid-START -> txdStart_o = 0 asynchronously; after release, all counts = 0 and CTRL threshold = 1.

Source files
------------

// File: rtl/serial_fifo_ctrl_pkg.sv
// Shared definitions for serial_fifo_ctrl: register offsets, bit positions, TX FSM states.
package serial_fifo_ctrl_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_LEVEL  = 2'd3;

   localparam int unsigned STAT_TX_NFULL  = 0;
   localparam int unsigned STAT_RX_NEMPTY = 1;
   localparam int unsigned STAT_RX_OVR    = 2;
   localparam int unsigned STAT_TX_OVF    = 3;

   localparam int unsigned CTRL_RX_IE    = 0;
   localparam int unsigned CTRL_TX_IE    = 1;
   localparam int unsigned CTRL_LOOPBACK = 2;
   localparam int unsigned CTRL_THR_LSB  = 8;
   localparam int unsigned THR_W         = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_GUARD = 2'd2
   } tx_state_t;

   typedef struct packed {
      logic [THR_W-1:0] rx_thresh;
      logic             tx_ie;
      logic             rx_ie;
   } ctrl_t;

   // A programmed threshold of zero behaves as one.
   function automatic logic [THR_W-1:0] eff_thresh(input logic [THR_W-1:0] t);
      return (t == '0) ? THR_W'(1) : t;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty from the MSB compare.
module sync_fifo #(
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned PW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [PW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // A pop in the same cycle frees the slot a push on a full FIFO needs.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/serial_fifo_ctrl.sv
// Buffered UART register block: RX/TX FIFOs, CTRL/LEVEL registers, threshold IRQ, TX start FSM.
// Optional build macro SERIAL_FIFO_LOOPBACK_EN adds CTRL bit2 internal TX->RX loopback.
module serial_fifo_ctrl
   import serial_fifo_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 16,
   parameter int unsigned CHAR_WIDTH    = 8,
   parameter int unsigned RX_THRESH_RST = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable_i,
   input  logic                  readEnable_i,
   input  logic [1:0]            addr_i,
   input  logic [31:0]           dataSave_i,
   output logic [31:0]           dataLoad_o,
   output logic                  int_o,
   input  logic                  rxdReady_i,
   input  logic [CHAR_WIDTH-1:0] rxdData_i,
   input  logic                  txdBusy_i,
   output logic                  txdStart_o,
   output logic [CHAR_WIDTH-1:0] txdData_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t             state_q, state_d;
   ctrl_t                 ctrl_q;
   logic                  rx_ovr_q, tx_ovf_q;
   logic                  tx_pop_c, start_d;
   logic                  rx_push, rx_pop, rx_full, rx_empty;
   logic                  tx_push, tx_full, tx_empty;
   logic                  status_rd, ctrl_wr, rx_ovr_set, tx_ovf_set, int_d;
   logic [PW-1:0]         rx_count, tx_count;
   logic [CHAR_WIDTH-1:0] rx_wdata, rx_head, tx_head;
   logic                  unused_ok;

`ifdef SERIAL_FIFO_LOOPBACK_EN
   logic loopback_q;
   assign rx_push  = loopback_q ? tx_pop_c  : rxdReady_i;
   assign rx_wdata = loopback_q ? txdData_o : rxdData_i;
   assign start_d  = (state_d == TX_START) & ~loopback_q;
`else
   assign rx_push  = rxdReady_i;
   assign rx_wdata = rxdData_i;
   assign start_d  = (state_d == TX_START);
`endif

   // Bus decode
   assign rx_pop     = enable_i & readEnable_i & (addr_i == REG_DATA) & ~rx_empty;
   assign status_rd  = enable_i & readEnable_i & (addr_i == REG_STATUS);
   assign tx_push    = enable_i & ~readEnable_i & (addr_i == REG_DATA);
   assign ctrl_wr    = enable_i & ~readEnable_i & (addr_i == REG_CTRL);
   assign rx_ovr_set = rx_push & rx_full & ~rx_pop;
   assign tx_ovf_set = tx_push & tx_full & ~tx_pop_c;
   assign unused_ok  = ^dataSave_i;

   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CHAR_WIDTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_wdata),
      .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
   );

   sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CHAR_WIDTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop_c), .wdata(dataSave_i[CHAR_WIDTH-1:0]),
      .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
   );

   // TX start FSM next state; the pop happens while in START
   always_comb begin
      state_d  = state_q;
      tx_pop_c = 1'b0;
      case (state_q)
         TX_IDLE:  if (!tx_empty && !txdBusy_i) state_d = TX_START;
         TX_START: begin
            tx_pop_c = 1'b1;
            state_d  = TX_GUARD;
         end
         TX_GUARD: state_d = TX_IDLE;
         default:  state_d = TX_IDLE;
      endcase
   end

   assign int_d = (ctrl_q.rx_ie & (16'(rx_count) >= 16'(eff_thresh(ctrl_q.rx_thresh))))
                | (ctrl_q.tx_ie & tx_empty & (state_q == TX_IDLE) & ~txdBusy_i);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= TX_IDLE;
         txdStart_o <= 1'b0;
         txdData_o  <= '0;
         int_o      <= 1'b0;
         ctrl_q     <= ctrl_t'{rx_thresh: THR_W'(RX_THRESH_RST), tx_ie: 1'b0, rx_ie: 1'b0};
         rx_ovr_q   <= 1'b0;
         tx_ovf_q   <= 1'b0;
`ifdef SERIAL_FIFO_LOOPBACK_EN
         loopback_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         txdStart_o <= start_d;
         if (state_d == TX_START) txdData_o <= tx_head;
         int_o      <= int_d;
         rx_ovr_q   <= (rx_ovr_q & ~status_rd) | rx_ovr_set;
         tx_ovf_q   <= (tx_ovf_q & ~status_rd) | tx_ovf_set;
         if (ctrl_wr) begin
            ctrl_q.rx_ie     <= dataSave_i[CTRL_RX_IE];
            ctrl_q.tx_ie     <= dataSave_i[CTRL_TX_IE];
            ctrl_q.rx_thresh <= dataSave_i[CTRL_THR_LSB +: THR_W];
`ifdef SERIAL_FIFO_LOOPBACK_EN
            loopback_q       <= dataSave_i[CTRL_LOOPBACK];
`endif
         end
      end
   end

   // Read mux
   always_comb begin
      dataLoad_o = '0;
      case (addr_i)
         REG_DATA:   if (!rx_empty) dataLoad_o = 32'(rx_head);
         REG_STATUS: begin
            dataLoad_o[STAT_TX_NFULL]  = ~tx_full;
            dataLoad_o[STAT_RX_NEMPTY] = ~rx_empty;
            dataLoad_o[STAT_RX_OVR]    = rx_ovr_q;
            dataLoad_o[STAT_TX_OVF]    = tx_ovf_q;
         end
         REG_CTRL: begin
            dataLoad_o[CTRL_RX_IE] = ctrl_q.rx_ie;
            dataLoad_o[CTRL_TX_IE] = ctrl_q.tx_ie;
            dataLoad_o[CTRL_THR_LSB +: THR_W] = ctrl_q.rx_thresh;
`ifdef SERIAL_FIFO_LOOPBACK_EN
            dataLoad_o[CTRL_LOOPBACK] = loopback_q;
`endif
         end
         default: dataLoad_o = {16'(tx_count), 16'(rx_count)};
      endcase
   end

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Directed self-checking bench for serial_fifo_ctrl (FIFO_DEPTH = 16, CHAR_WIDTH = 8).
module tb_serial_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_i, readEnable_i, rxdReady_i, txdBusy_i;
   logic [1:0]  addr_i;
   logic [31:0] dataSave_i;
   logic [31:0] dataLoad_o;
   logic        int_o, txdStart_o;
   logic [7:0]  rxdData_i, txdData_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int q_data[$];
   int q_cyc[$];
   logic [31:0] rd;

   serial_fifo_ctrl #(.FIFO_DEPTH(16), .CHAR_WIDTH(8), .RX_THRESH_RST(1)) dut (
      .clk(clk), .rst(rst), .enable_i(enable_i), .readEnable_i(readEnable_i),
      .addr_i(addr_i), .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o), .int_o(int_o),
      .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i), .txdBusy_i(txdBusy_i),
      .txdStart_o(txdStart_o), .txdData_o(txdData_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every cycle the start pulse is seen high
   always @(negedge clk) begin
      if (txdStart_o === 1'b1) begin
         q_data.push_back(int'(txdData_o));
         q_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // All bus tasks are entered and left at a falling edge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      enable_i = 1'b1; readEnable_i = 1'b0; addr_i = a; dataSave_i = d;
      @(negedge clk);
      enable_i = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      enable_i = 1'b1; readEnable_i = 1'b1; addr_i = a;
      #1 d = dataLoad_o;
      @(negedge clk);
      enable_i = 1'b0;
   endtask

   task automatic rx_char(input logic [7:0] c);
      rxdReady_i = 1'b1; rxdData_i = c;
      @(negedge clk);
      rxdReady_i = 1'b0;
   endtask

   initial begin
      rst = 1'b0; enable_i = 1'b0; readEnable_i = 1'b0; addr_i = 2'd0;
      dataSave_i = '0; rxdReady_i = 1'b0; rxdData_i = '0; txdBusy_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Reset state
      chk("rst_int", 32'(int_o), 32'h0);
      chk("rst_start", 32'(txdStart_o), 32'h0);
      chk("rst_txdata", 32'(txdData_o), 32'h0);
      bus_read(2'd1, rd); chk("rst_status", rd, 32'h1);
      bus_read(2'd2, rd); chk("rst_ctrl", rd, 32'h0100);
      bus_read(2'd3, rd); chk("rst_level", rd, 32'h0);

      // Three characters out with the transmitter idle
      bus_write(2'd0, 32'h41);
      bus_write(2'd0, 32'h42);
      bus_write(2'd0, 32'h43);
      repeat (15) @(negedge clk);
      chk("tx3_pulses", 32'(q_data.size()), 32'd3);
      if (q_data.size() == 3) begin
         chk("tx3_d0", 32'(q_data[0]), 32'h41);
         chk("tx3_d1", 32'(q_data[1]), 32'h42);
         chk("tx3_d2", 32'(q_data[2]), 32'h43);
         chk("tx3_gap01", 32'(q_cyc[1] - q_cyc[0]), 32'd3);
         chk("tx3_gap12", 32'(q_cyc[2] - q_cyc[1]), 32'd3);
      end
      bus_read(2'd3, rd); chk("tx3_level", rd, 32'h0);

      // Undefined CTRL bits and read-only registers
      bus_write(2'd2, 32'hFFFF_00F4);
      bus_read(2'd2, rd);
`ifdef SERIAL_FIFO_LOOPBACK_EN
      chk("ctrl_undef", rd, 32'h4);
      bus_write(2'd2, 32'h0);
`else
      chk("ctrl_undef", rd, 32'h0);
`endif
      bus_write(2'd3, 32'hFFFF_FFFF);
      bus_write(2'd1, 32'hFFFF_FFFF);
      bus_read(2'd3, rd); chk("level_ro", rd, 32'h0);
      bus_read(2'd1, rd); chk("status_ro", rd, 32'h1);

      // TX overflow with the transmitter busy
      txdBusy_i = 1'b1;
      q_data.delete(); q_cyc.delete();
      for (int i = 0; i < 16; i++) bus_write(2'd0, 32'hABCD_0060 + 32'(i));
      bus_read(2'd1, rd); chk("txfull_status", rd, 32'h0);
      bus_write(2'd0, 32'h7E);
      bus_read(2'd1, rd); chk("txovf_status", rd, 32'h8);
      bus_read(2'd1, rd); chk("txovf_cleared", rd, 32'h0);
      bus_read(2'd3, rd); chk("txfull_level", rd, 32'h0010_0000);
      chk("busy_no_start", 32'(q_data.size()), 32'd0);
      txdBusy_i = 1'b0;
      repeat (60) @(negedge clk);
      chk("drain_pulses", 32'(q_data.size()), 32'd16);
      if (q_data.size() == 16) begin
         chk("drain_first", 32'(q_data[0]), 32'h60);
         chk("drain_last", 32'(q_data[15]), 32'h6F);
      end
      bus_read(2'd3, rd); chk("drain_level", rd, 32'h0);

      // RX overrun on the 17th character
      for (int i = 0; i < 17; i++) rx_char(8'(i));
      bus_read(2'd3, rd); chk("rxovr_level", rd, 32'h10);
      bus_read(2'd1, rd); chk("rxovr_status", rd, 32'h7);
      for (int i = 0; i < 16; i++) begin
         bus_read(2'd0, rd); chk($sformatf("rx_pop%0d", i), rd, 32'(i));
      end
      bus_read(2'd0, rd); chk("rx_empty_read", rd, 32'h0);
      bus_read(2'd3, rd); chk("rx_empty_level", rd, 32'h0);
      bus_read(2'd1, rd); chk("rx_empty_status", rd, 32'h1);

      // Simultaneous pop and push on a full RX FIFO
      for (int i = 0; i < 16; i++) rx_char(8'h20 + 8'(i));
      enable_i = 1'b1; readEnable_i = 1'b1; addr_i = 2'd0;
      rxdReady_i = 1'b1; rxdData_i = 8'h99;
      #1 rd = dataLoad_o;
      @(negedge clk);
      enable_i = 1'b0; rxdReady_i = 1'b0;
      chk("full_pp_head", rd, 32'h20);
      bus_read(2'd1, rd); chk("full_pp_status", rd, 32'h3);
      bus_read(2'd3, rd); chk("full_pp_level", rd, 32'h10);
      for (int i = 1; i < 16; i++) begin
         bus_read(2'd0, rd); chk($sformatf("full_pp_pop%0d", i), rd, 32'h20 + 32'(i));
      end
      bus_read(2'd0, rd); chk("full_pp_last", rd, 32'h99);

      // RX threshold interrupt (threshold 3)
      bus_write(2'd2, 32'h0301);
      bus_read(2'd2, rd); chk("ctrl_rb", rd, 32'h0301);
      rx_char(8'h51);
      rx_char(8'h52);
      @(negedge clk);
      chk("irq_below", 32'(int_o), 32'h0);
      rx_char(8'h53);
      chk("irq_lag", 32'(int_o), 32'h0);
      @(negedge clk);
      chk("irq_set", 32'(int_o), 32'h1);
      bus_read(2'd0, rd); chk("irq_pop", rd, 32'h51);
      chk("irq_hold", 32'(int_o), 32'h1);
      @(negedge clk);
      chk("irq_clr", 32'(int_o), 32'h0);
      bus_read(2'd0, rd); chk("irq_drain0", rd, 32'h52);
      bus_read(2'd0, rd); chk("irq_drain1", rd, 32'h53);

      // Threshold 0 behaves as 1
      bus_write(2'd2, 32'h0001);
      rx_char(8'h77);
      @(negedge clk);
      chk("thr0_irq", 32'(int_o), 32'h1);
      bus_write(2'd2, 32'h0);
      bus_read(2'd0, rd); chk("thr0_pop", rd, 32'h77);

      // TX-empty interrupt follows txdBusy_i
      bus_write(2'd2, 32'h0002);
      @(negedge clk);
      chk("txirq_set", 32'(int_o), 32'h1);
      txdBusy_i = 1'b1;
      @(negedge clk);
      chk("txirq_busy", 32'(int_o), 32'h0);
      txdBusy_i = 1'b0;
      bus_write(2'd2, 32'h0);

      // Reset while the start pulse is high
      bus_write(2'd2, 32'h0500);
      rx_char(8'h11);
      bus_write(2'd0, 32'h5A);
      @(posedge clk);
      #2;
      chk("mid_start_hi", 32'(txdStart_o), 32'h1);
      chk("mid_start_data", 32'(txdData_o), 32'h5A);
      rst = 1'b0;
      #1;
      chk("async_start_lo", 32'(txdStart_o), 32'h0);
      chk("async_txdata", 32'(txdData_o), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      bus_read(2'd3, rd); chk("post_rst_level", rd, 32'h0);
      bus_read(2'd2, rd); chk("post_rst_ctrl", rd, 32'h0100);
      bus_read(2'd1, rd); chk("post_rst_status", rd, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
